// File: rtl/fir_serial_sched.sv
// Serial symmetric FIR: one shared pre-add/multiply per cycle over HALF pairs.
// Define FIR_SKID_EN to add a one-entry input skid register.
module fir_serial_sched #(
   parameter int DW   = 12,
   parameter int CW   = 12,
   parameter int TAPS = 16,
   parameter int OW   = 29
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        xin_en,
   input  logic [DW-1:0]               xin,
   output logic                        xin_ready,
   input  logic                        cfg_we,
   input  logic [$clog2(TAPS/2)-1:0]   cfg_addr,
   input  logic [CW-1:0]               cfg_data,
   output logic                        cfg_err,
   output logic                        busy,
   output logic                        overrun,
   output logic                        yout_valid,
   output logic [OW-1:0]               yout
);
   localparam int HALF = TAPS / 2;
   localparam int AW   = $clog2(HALF);
   localparam int PW   = $clog2(TAPS);
   localparam int SW   = DW + 1;
   localparam int MW   = SW + CW;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   function automatic logic [CW-1:0] f_coe_init(input int i);
      case (i)
         0:       return CW'(11);
         1:       return CW'(31);
         2:       return CW'(63);
         3:       return CW'(104);
         4:       return CW'(152);
         5:       return CW'(198);
         6:       return CW'(235);
         7:       return CW'(255);
         default: return '0;
      endcase
   endfunction

   state_t          r_state, w_next;
   logic [DW-1:0]   r_buf [TAPS];
   logic [CW-1:0]   r_coe [HALF];
   logic [PW-1:0]   r_wp, r_base;
   logic [AW-1:0]   r_k;
   logic            r_dcnt;
   logic [SW-1:0]   r_p;
   logic [CW-1:0]   r_c;
   logic [MW-1:0]   r_m;
   logic            r_pv, r_mv;
   logic [OW-1:0]   r_acc, r_yout;
   logic            r_yv, r_ovr, r_cerr;

   logic            w_open, w_launch, w_ready, w_drop;
   logic [DW-1:0]   w_ldata;
   logic [PW-1:0]   w_ia, w_ib;
   logic [SW-1:0]   w_psum;
   logic [MW-1:0]   w_prod;

   assign w_open = (r_state == S_IDLE) || (r_state == S_DONE);

`ifdef FIR_SKID_EN
   logic            r_skid_full;
   logic [DW-1:0]   r_skid;

   assign w_launch = w_open && (r_skid_full || xin_en);
   assign w_ldata  = r_skid_full ? r_skid : xin;
   assign w_ready  = w_open || !r_skid_full;
   assign w_drop   = xin_en && r_skid_full && (r_state != S_DONE);

   // A held sample always launches before a newly arriving one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_skid_full <= 1'b0;
         r_skid      <= '0;
      end else if (w_open) begin
         if (r_skid_full) begin
            r_skid_full <= xin_en;
            if (xin_en) r_skid <= xin;
         end
      end else if (xin_en && !r_skid_full) begin
         r_skid      <= xin;
         r_skid_full <= 1'b1;
      end
   end
`else
   assign w_launch = xin_en && w_open;
   assign w_ldata  = xin;
   assign w_ready  = w_open;
   assign w_drop   = xin_en && !w_open;
`endif

   // Pair k folds the k-th newest sample with its mirror tap.
   assign w_ia   = r_base - PW'(r_k);
   assign w_ib   = r_base + PW'(r_k) + PW'(1);
   assign w_psum = {1'b0, r_buf[w_ia]} + {1'b0, r_buf[w_ib]};
   assign w_prod = {{CW{1'b0}}, r_p} * {{SW{1'b0}}, r_c};

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:  if (w_launch) w_next = S_RUN;
         S_RUN:   if (r_k == AW'(HALF - 1)) w_next = S_DRAIN;
         S_DRAIN: if (r_dcnt) w_next = S_DONE;
         S_DONE:  w_next = w_launch ? S_RUN : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         for (int i = 0; i < TAPS; i++) r_buf[i] <= '0;
         for (int i = 0; i < HALF; i++) r_coe[i] <= f_coe_init(i);
         r_wp    <= '0;
         r_base  <= '0;
         r_k     <= '0;
         r_dcnt  <= 1'b0;
         r_p     <= '0;
         r_c     <= '0;
         r_m     <= '0;
         r_pv    <= 1'b0;
         r_mv    <= 1'b0;
         r_acc   <= '0;
         r_yout  <= '0;
         r_yv    <= 1'b0;
         r_ovr   <= 1'b0;
         r_cerr  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_ovr   <= w_drop;
         r_cerr  <= cfg_we && (r_state != S_IDLE);
         if (cfg_we && (r_state == S_IDLE)) r_coe[cfg_addr] <= cfg_data;
         if (w_launch) begin
            r_buf[r_wp] <= w_ldata;
            r_base      <= r_wp;
            r_wp        <= r_wp + PW'(1);
            r_acc       <= '0;
            r_k         <= '0;
         end else begin
            if (r_state == S_RUN) r_k <= r_k + AW'(1);
            if (r_mv) r_acc <= r_acc + OW'(r_m);
         end
         r_dcnt <= (r_state == S_DRAIN) ? !r_dcnt : 1'b0;
         r_pv   <= (r_state == S_RUN);
         r_mv   <= r_pv;
         if (r_state == S_RUN) begin
            r_p <= w_psum;
            r_c <= r_coe[r_k];
         end
         if (r_pv) r_m <= w_prod;
         r_yv <= (r_state == S_DONE);
         if (r_state == S_DONE) r_yout <= r_acc;
      end
   end

   assign xin_ready  = w_ready;
   assign busy       = (r_state != S_IDLE);
   assign overrun    = r_ovr;
   assign cfg_err    = r_cerr;
   assign yout_valid = r_yv;
   assign yout       = r_yout;
endmodule

// File: tb/tb_fir_serial_sched.sv
// Randomised bench for fir_serial_sched against a convolution-level model.
// Build with FIR_SKID_EN defined to also exercise the skid register.
module tb_fir_serial_sched;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        xin_en = 1'b0;
   logic [11:0] xin = '0;
   logic        cfg_we = 1'b0;
   logic [2:0]  cfg_addr = '0;
   logic [11:0] cfg_data = '0;
   logic        xin_ready, cfg_err, busy, overrun, yout_valid;
   logic [28:0] yout;

   fir_serial_sched dut (
      .clk(clk), .rst(rst), .xin_en(xin_en), .xin(xin),
      .xin_ready(xin_ready), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .cfg_err(cfg_err), .busy(busy),
      .overrun(overrun), .yout_valid(yout_valid), .yout(yout)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Model state: sample history (newest first) and coefficient table.
   longint hist [16];
   int     coe [8];
   int     due_q [$];
   longint val_q [$];
   int     next_ok, idle_at;
   bit     m_init = 0;
   bit     sk_full = 0;
   int     sk_data = 0;
   bit     exp_v, exp_ready, exp_busy, exp_ovr, exp_cerr;
   longint exp_y;

   longint obs [$];
   int     obs_t [$];

   int dflt [8] = '{11, 31, 63, 104, 152, 198, 235, 255};
   longint himp [17] = '{11, 31, 63, 104, 152, 198, 235, 255,
                         255, 235, 198, 152, 104, 63, 31, 11, 0};

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   task automatic model_step();
      int e;
      bit can, launch, ovr;
      int ld;
      longint y;
      cyc++;
      e = cyc;
      if (rst) begin
         m_init = 1;
         for (int i = 0; i < 16; i++) hist[i] = 0;
         for (int i = 0; i < 8; i++) coe[i] = dflt[i];
         due_q.delete();
         val_q.delete();
         next_ok = e + 1;
         idle_at = e + 1;
         sk_full = 0;
         exp_v = 0; exp_y = 0; exp_ready = 1;
         exp_busy = 0; exp_ovr = 0; exp_cerr = 0;
         return;
      end
      if (!m_init) return;
      exp_v = 0;
      if (due_q.size() > 0 && due_q[0] == e) begin
         exp_v = 1;
         exp_y = val_q[0];
         void'(due_q.pop_front());
         void'(val_q.pop_front());
      end
      exp_cerr = cfg_we && (e < idle_at);
      if (cfg_we && e >= idle_at) coe[cfg_addr] = int'(cfg_data);
      can = (e >= next_ok);
      launch = 0;
      ovr = 0;
      ld = 0;
`ifdef FIR_SKID_EN
      if (can) begin
         if (sk_full) begin
            launch = 1;
            ld = sk_data;
            sk_full = xin_en;
            if (xin_en) sk_data = int'(xin);
         end else if (xin_en) begin
            launch = 1;
            ld = int'(xin);
         end
      end else if (xin_en) begin
         if (!sk_full) begin
            sk_full = 1;
            sk_data = int'(xin);
         end else ovr = 1;
      end
`else
      if (xin_en) begin
         if (can) begin
            launch = 1;
            ld = int'(xin);
         end else ovr = 1;
      end
`endif
      if (launch) begin
         for (int i = 15; i > 0; i--) hist[i] = hist[i-1];
         hist[0] = ld;
         y = 0;
         for (int j = 0; j < 16; j++)
            y += longint'(j < 8 ? coe[j] : coe[15-j]) * hist[j];
         due_q.push_back(e + 11);
         val_q.push_back(y);
         next_ok = e + 11;
         idle_at = e + 12;
      end
      exp_ovr = ovr;
`ifdef FIR_SKID_EN
      exp_ready = (e + 1 >= next_ok) || !sk_full;
`else
      exp_ready = (e + 1 >= next_ok);
`endif
      exp_busy = (e + 1 < idle_at);
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (m_init) begin
         chk("yout_valid", yout_valid, exp_v);
         chk("yout", yout, exp_y);
         chk("xin_ready", xin_ready, exp_ready);
         chk("busy", busy, exp_busy);
         chk("overrun", overrun, exp_ovr);
         chk("cfg_err", cfg_err, exp_cerr);
         if (yout_valid) begin
            obs.push_back(longint'(yout));
            obs_t.push_back(cyc);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x);
      int n = 0;
      while (!xin_ready && n < 40) begin
         tick();
         n++;
      end
      if (n >= 40) timeout("send_ready");
      xin_en = 1'b1;
      xin = 12'(x);
      tick();
      xin_en = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 80) begin
         tick();
         n++;
      end
      if (n >= 80) timeout("wait_idle");
      tick();
      tick();
   endtask

   task automatic check_impulse(input string name);
      chk({name, "_count"}, obs.size(), 17);
      for (int i = 0; i < 17 && i < obs.size(); i++)
         chk(name, obs[i], himp[i]);
   endtask

   initial begin
      int t0;
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      chk("rst_yout", yout, 0);
      chk("rst_valid", yout_valid, 0);
      chk("rst_ready", xin_ready, 1);
      chk("rst_busy", busy, 0);

      obs.delete();
      send(1);
      repeat (16) send(0);
      wait_idle();
      check_impulse("impulse");

      obs.delete();
      repeat (20) send(4095);
      wait_idle();
      chk("step_count", obs.size(), 20);
      chk("step_last", obs.size() > 0 ? obs[obs.size()-1] : -1, 8591310);

      obs.delete();
      obs_t.delete();
      xin_en = 1'b1;
      repeat (60) begin
         xin = 12'($urandom_range(0, 4095));
         tick();
      end
      xin_en = 1'b0;
      wait_idle();
`ifndef FIR_SKID_EN
      chk("tput_count", obs.size(), 6);
`endif
      for (int i = 1; i < obs_t.size(); i++)
         chk("tput_spacing", obs_t[i] - obs_t[i-1], 11);

      repeat (16) send(0);
      wait_idle();
      cfg_we = 1'b1;
      cfg_addr = 3'd0;
      cfg_data = 12'd100;
      tick();
      cfg_we = 1'b0;
      obs.delete();
      send(1);
      cfg_we = 1'b1;
      cfg_addr = 3'd3;
      cfg_data = 12'd7;
      tick();
      cfg_we = 1'b0;
      chk("cfg_err_busy", cfg_err, 1);
      repeat (3) send(0);
      wait_idle();
      chk("cfg_new0", obs.size() > 0 ? obs[0] : -1, 100);
      chk("cfg_keep3", obs.size() > 3 ? obs[3] : -1, 104);

      obs.delete();
      send(1);
      repeat (3) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      repeat (15) tick();
      chk("midrst_novalid", obs.size(), 0);
      chk("midrst_yout", yout, 0);
      send(1);
      repeat (16) send(0);
      wait_idle();
      check_impulse("post_rst");

      repeat (400) begin
         xin_en = ($urandom_range(0, 3) == 0);
         xin = 12'($urandom);
         cfg_we = ($urandom_range(0, 15) == 0);
         cfg_addr = 3'($urandom);
         cfg_data = 12'($urandom);
         tick();
      end
      xin_en = 1'b0;
      cfg_we = 1'b0;
      wait_idle();

`ifdef FIR_SKID_EN
      rst = 1'b1;
      tick();
      rst = 1'b0;
      obs.delete();
      obs_t.delete();
      send(5);
      t0 = cyc;
      tick();
      tick();
      xin_en = 1'b1;
      xin = 12'd9;
      tick();
      xin_en = 1'b0;
      wait_idle();
      chk("skid_count", obs_t.size(), 2);
      chk("skid_t0", obs_t.size() > 0 ? obs_t[0] - t0 : -1, 11);
      chk("skid_t1", obs_t.size() > 1 ? obs_t[1] - t0 : -1, 22);
`else
      t0 = cyc;
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end
endmodule
